// File: rtl/axi_slave_responder_if.sv
// rtl/axi_slave_responder_if.sv - AXI bus bundle (AW/W/B/AR/R) for axi_slave_responder
interface axi_slave_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_W_WIDTH = 5,
    parameter int ID_R_WIDTH = 5
);
    logic [ID_W_WIDTH-1:0] awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;

    logic [31:0]           wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_W_WIDTH-1:0] bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_R_WIDTH-1:0] arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;

    logic [ID_R_WIDTH-1:0] rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awvalid, input awready,
        output wdata, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awvalid, output awready,
        input wdata, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_slave_responder.sv
// rtl/axi_slave_responder.sv - AXI subordinate model with programmable latency; optional WDATA_CHECK_EN
module axi_slave_responder #(
    parameter int ADDR_WIDTH   = 16,
    parameter int ID_W_WIDTH   = 5,
    parameter int ID_R_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 8,
    parameter int RESPONDER_ID = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi_slave_responder_if.slave  s_axi,
    input  logic [7:0]            delay_i,
    output logic [15:0]           wr_count_o,
    output logic [15:0]           rd_count_o,
    output logic [15:0]           err_count_o,
    output logic                  idle_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ID_R_WIDTH + ADDR_WIDTH + 8;
    localparam logic [7:0] TAG = 8'(RESPONDER_ID);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DELAY, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_BURST} r_state_t;

    // ---------------- write path ----------------
    w_state_t              w_state;
    logic [ID_W_WIDTH-1:0] w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_beat;
    logic [7:0]            w_cnt;
    logic                  w_err;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [31:0]           w_expect;
    logic                  beat_bad;

    assign w_expect = {w_addr[15:0] + {6'd0, w_beat, 2'b00}, TAG, w_beat};

    // Decide whether the current W beat deviates from the address-derived pattern
`ifdef WDATA_CHECK_EN
    always_comb begin
        beat_bad = (s_axi.wdata != w_expect);
    end
    logic unused_w;
    assign unused_w = ^{s_axi.awlen};
`else
    always_comb begin
        beat_bad = 1'b0;
    end
    logic unused_w;
    assign unused_w = ^{s_axi.awlen, s_axi.wdata, w_expect};
`endif

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = w_id;
    assign s_axi.bresp   = w_err ? 2'b10 : 2'b00;

    // Write FSM: accept AW, collect W beats, wait out delay_i, hold B until bready
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state     <= W_IDLE;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            w_id        <= '0;
            w_addr      <= '0;
            w_beat      <= 8'd0;
            w_cnt       <= 8'd0;
            w_err       <= 1'b0;
            wr_count_o  <= 16'd0;
            err_count_o <= 16'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi.awvalid) begin
                        w_id      <= s_axi.awid;
                        w_addr    <= s_axi.awaddr;
                        w_beat    <= 8'd0;
                        w_err     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi.wvalid && wready_q) begin
                        w_beat <= w_beat + 8'd1;
                        if (beat_bad) begin
                            w_err       <= 1'b1;
                            err_count_o <= err_count_o + 16'd1;
                        end
                        if (s_axi.wlast) begin
                            wready_q <= 1'b0;
                            if (delay_i == 8'd0) begin
                                bvalid_q <= 1'b1;
                                w_state  <= W_RESP;
                            end else begin
                                w_cnt   <= delay_i;
                                w_state <= W_DELAY;
                            end
                        end
                    end
                end
                W_DELAY: begin
                    w_cnt <= w_cnt - 8'd1;
                    if (w_cnt == 8'd1) begin
                        bvalid_q <= 1'b1;
                        w_state  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_count_o <= wr_count_o + 16'd1;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic [PTR_W:0]        fifo_cnt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ENT_W-1:0]      head;
    logic [ID_R_WIDTH-1:0] head_id;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [7:0]            head_len;
    logic                  push;
    logic                  pop_now;

    r_state_t              r_state;
    logic                  rvalid_q;
    logic [ID_R_WIDTH-1:0] r_id;
    logic [15:0]           r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [7:0]            r_cnt;
    logic                  r_last;

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_len   = head[7:0];
    assign head_addr  = head[ADDR_WIDTH+7:8];
    assign head_id    = head[ENT_W-1:ADDR_WIDTH+8];
    assign r_last     = (r_beat == r_len);

    // A pop happens from idle, or on the final R handshake so bursts can chain without a gap
    assign pop_now = !fifo_empty &&
                     ((r_state == R_IDLE) ||
                      (r_state == R_BURST && rvalid_q && s_axi.rready && r_last));
    assign s_axi.arready = !fifo_full || pop_now;
    assign push          = s_axi.arvalid && s_axi.arready;

    assign s_axi.rvalid = rvalid_q;
    assign s_axi.rid    = r_id;
    assign s_axi.rdata  = {r_addr, TAG, r_beat};
    assign s_axi.rresp  = 2'b00;
    assign s_axi.rlast  = r_last;

    // AR request storage; entries need no reset since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {s_axi.arid, s_axi.araddr, s_axi.arlen};
        end
    end

    // AR FIFO pointers; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (pop_now) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Read FSM: pop a request, wait out delay_i, stream the INCR burst
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= R_IDLE;
            rvalid_q   <= 1'b0;
            r_id       <= '0;
            r_addr     <= 16'd0;
            r_len      <= 8'd0;
            r_beat     <= 8'd0;
            r_cnt      <= 8'd0;
            rd_count_o <= 16'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                end
                R_DELAY: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        rvalid_q <= 1'b1;
                        r_state  <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (s_axi.rready) begin
                        if (r_last) begin
                            rvalid_q   <= 1'b0;
                            rd_count_o <= rd_count_o + 16'd1;
                            r_state    <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_addr <= r_addr + 16'd4;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
            if (pop_now) begin
                r_id   <= head_id;
                r_addr <= head_addr[15:0];
                r_len  <= head_len;
                r_beat <= 8'd0;
                if (delay_i == 8'd0) begin
                    rvalid_q <= 1'b1;
                    r_state  <= R_BURST;
                end else begin
                    rvalid_q <= 1'b0;
                    r_cnt    <= delay_i;
                    r_state  <= R_DELAY;
                end
            end
        end
    end

    assign idle_o = (w_state == W_IDLE) && (r_state == R_IDLE) && fifo_empty;
endmodule

// File: tb/tb_axi_slave_responder.sv
// tb/tb_axi_slave_responder.sv - self-checking bench for axi_slave_responder (WDATA_CHECK_EN aware)
module tb_axi_slave_responder;
    localparam int AW  = 16;
    localparam int IDW = 5;
    localparam int IDR = 5;
    localparam logic [7:0] RID = 8'hA5;
`ifdef WDATA_CHECK_EN
    localparam logic [1:0]  BAD_RESP = 2'b10;
    localparam logic [15:0] ERR_STEP = 16'd1;
`else
    localparam logic [1:0]  BAD_RESP = 2'b00;
    localparam logic [15:0] ERR_STEP = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  delay = 8'd0;
    logic [15:0] wr_count, rd_count, err_count;
    logic        idle;

    axi_slave_responder_if #(.ADDR_WIDTH(AW), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR)) bus ();

    axi_slave_responder #(
        .ADDR_WIDTH(AW), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR),
        .FIFO_DEPTH(8), .RESPONDER_ID(32'hA5)
    ) dut (
        .clk_i(clk), .rst_i(rst), .s_axi(bus), .delay_i(delay),
        .wr_count_o(wr_count), .rd_count_o(rd_count), .err_count_o(err_count),
        .idle_o(idle)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [15:0] base, input int k);
        return {base + 16'(4 * k), RID, 8'(k)};
    endfunction

    typedef struct packed {logic [IDR-1:0] id; logic [31:0] data; logic last;} rbeat_t;
    typedef struct packed {logic [IDW-1:0] id; logic [1:0] resp;} bexp_t;
    rbeat_t exp_r[$];
    bexp_t  exp_b[$];

    logic [15:0]    m_wr = 0, m_rd = 0, m_err = 0;
    bit             w_busy = 0, w_data = 0, w_bad = 0;
    logic [IDW-1:0] mw_id;
    logic [15:0]    mw_addr;
    int             mw_beat;
    bit             r_hold = 0, b_hold = 0;
    rbeat_t         r_prev;
    bexp_t          b_prev;

    // Transaction-level reference: tracks outstanding bursts and checks every cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_r.delete(); exp_b.delete();
            m_wr = 0; m_rd = 0; m_err = 0;
            w_busy = 0; w_data = 0; w_bad = 0; r_hold = 0; b_hold = 0;
        end else begin
            check("wr_count", wr_count, m_wr);
            check("rd_count", rd_count, m_rd);
            check("err_count", err_count, m_err);
            check("idle", idle, !(w_busy || exp_r.size() != 0));
            check("awready", bus.awready, !w_busy);
            check("wready", bus.wready, w_data);
            if (r_hold) begin
                check("r_hold_valid", bus.rvalid, 1);
                check("r_hold_data", bus.rdata, r_prev.data);
                check("r_hold_id", bus.rid, r_prev.id);
                check("r_hold_last", bus.rlast, r_prev.last);
            end
            if (b_hold) begin
                check("b_hold_valid", bus.bvalid, 1);
                check("b_hold_id", bus.bid, b_prev.id);
                check("b_hold_resp", bus.bresp, b_prev.resp);
            end
            r_hold = bus.rvalid && !bus.rready;
            r_prev = '{id: bus.rid, data: bus.rdata, last: bus.rlast};
            b_hold = bus.bvalid && !bus.bready;
            b_prev = '{id: bus.bid, resp: bus.bresp};

            if (bus.rvalid && bus.rready) begin
                check("r_expected", exp_r.size() != 0, 1);
                if (exp_r.size() != 0) begin
                    rbeat_t e;
                    e = exp_r.pop_front();
                    check("rid", bus.rid, e.id);
                    check("rdata", bus.rdata, e.data);
                    check("rlast", bus.rlast, e.last);
                    check("rresp", bus.rresp, 0);
                    if (e.last) m_rd = m_rd + 16'd1;
                end
            end
            if (bus.bvalid && bus.bready) begin
                check("b_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    bexp_t e;
                    e = exp_b.pop_front();
                    check("bid", bus.bid, e.id);
                    check("bresp", bus.bresp, e.resp);
                end
                m_wr = m_wr + 16'd1;
                w_busy = 0;
            end
            if (bus.awvalid && bus.awready) begin
                w_busy = 1; w_data = 1; w_bad = 0;
                mw_id = bus.awid; mw_addr = bus.awaddr; mw_beat = 0;
            end
            if (bus.wvalid && bus.wready) begin
                if (bus.wdata != pattern(mw_addr, mw_beat)) begin
                    w_bad = 1;
                    m_err = m_err + ERR_STEP;
                end
                if (bus.wlast) begin
                    w_data = 0;
                    exp_b.push_back('{id: mw_id, resp: (w_bad ? BAD_RESP : 2'b00)});
                end
                mw_beat++;
            end
            if (bus.arvalid && bus.arready) begin
                for (int k = 0; k <= int'(bus.arlen); k++)
                    exp_r.push_back('{id: bus.arid, data: pattern(bus.araddr, k),
                                      last: (k == int'(bus.arlen))});
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_ar(input logic [IDR-1:0] id, input logic [15:0] addr, input logic [7:0] len);
        bit done = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.arready) done = 1;
            @(posedge clk); #1;
        end
        bus.arvalid = 0;
        check("ar_handshake", 32'(done), 1);
    endtask

    task automatic do_aw(input logic [IDW-1:0] id, input logic [15:0] addr, input logic [7:0] len);
        bit done = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.awready) done = 1;
            @(posedge clk); #1;
        end
        bus.awvalid = 0;
        check("aw_handshake", 32'(done), 1);
    endtask

    task automatic do_w(input logic [31:0] data, input logic last);
        bit done = 0;
        bus.wdata = data; bus.wlast = last; bus.wvalid = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.wready) done = 1;
            @(posedge clk); #1;
        end
        bus.wvalid = 0; bus.wlast = 0;
        check("w_handshake", 32'(done), 1);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit seen = 0;
        resp = 2'bxx;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.bvalid) begin seen = 1; resp = bus.bresp; end
        end
        check("b_seen", 32'(seen), 1);
    endtask

    task automatic wait_quiet();
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (idle && exp_r.size() == 0 && exp_b.size() == 0) ok = 1;
        end
        check("drain", 32'(ok), 1);
    endtask

    logic [31:0] lit [4];
    int          n;
    logic [1:0]  resp;

    initial begin
        lit[0] = 32'h0100A500; lit[1] = 32'h0104A501;
        lit[2] = 32'h0108A502; lit[3] = 32'h010CA503;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awvalid = 0;
        bus.wdata = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arvalid = 0; bus.rready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // reset state
        @(negedge clk);
        check("rst_awready", bus.awready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_wready", bus.wready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_idle", idle, 1);
        check("rst_counts", {wr_count, rd_count} | {16'd0, err_count}, 0);

        // zero-delay 4-beat read, literal data
        step();
        delay = 0; bus.rready = 1;
        do_ar(5'd3, 16'h0100, 8'd3);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rvalid && n < 20);
        check("ar_to_rvalid", n, 2);
        for (int k = 0; k < 4; k++) begin
            check("lit_rdata", bus.rdata, lit[k]);
            check("lit_rlast", bus.rlast, (k == 3));
            if (k < 3) @(negedge clk);
        end
        step();
        wait_quiet();
        check("lit_rd_count", rd_count, 16'd1);

        // delay 5 single-beat write with stalled B
        step();
        delay = 8'd5; bus.bready = 0;
        do_aw(5'h0A, 16'h0200, 8'd0);
        do_w(pattern(16'h0200, 0), 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.bvalid && n < 30);
        check("wlast_to_bvalid", n, 6);
        for (int i = 0; i < 3; i++) begin
            check("lit_bid", bus.bid, 5'h0A);
            @(negedge clk);
        end
        step();
        bus.bready = 1;
        wait_quiet();
        check("lit_wr_count", wr_count, 16'd1);

        // multi-beat write with correct data
        step();
        delay = 8'd2;
        do_aw(5'd1, 16'h1000, 8'd3);
        for (int k = 0; k < 4; k++) do_w(pattern(16'h1000, k), k == 3);
        wait_quiet();

        // corrupted beat 1, then a clean burst to the same address
        step();
        do_aw(5'd2, 16'h0200, 8'd1);
        do_w(pattern(16'h0200, 0), 1'b0);
        do_w(pattern(16'h0200, 1) ^ 32'h1, 1'b1);
        wait_b(resp);
        check("lit_bad_bresp", resp, BAD_RESP);
        wait_quiet();
        check("lit_err_count", err_count, ERR_STEP);
        step();
        do_aw(5'd4, 16'h0200, 8'd1);
        do_w(pattern(16'h0200, 0), 1'b0);
        do_w(pattern(16'h0200, 1), 1'b1);
        wait_b(resp);
        check("lit_good_bresp", resp, 2'b00);
        wait_quiet();
        check("lit_err_after_good", err_count, ERR_STEP);

        // W offered before AW must stall
        step();
        bus.wdata = 32'hDEAD0000; bus.wlast = 1; bus.wvalid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("w_before_aw", bus.wready, 0);
        end
        step();
        bus.wvalid = 0; bus.wlast = 0;

        // delayed read with rready toggling
        step();
        delay = 8'd3; bus.rready = 0;
        do_ar(5'd7, 16'h2000, 8'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rvalid && n < 30);
        check("delayed_ar_to_rvalid", n, 5);
        for (int i = 0; i < 12; i++) begin
            step();
            bus.rready = i[0];
        end
        bus.rready = 1;
        wait_quiet();

        // nine ARs against an 8-deep FIFO with R stalled
        step();
        delay = 0; bus.rready = 0;
        for (int i = 0; i < 9; i++) do_ar(IDR'(i), 16'h4000 + 16'(i * 256), 8'd1);
        @(negedge clk);
        check("fifo_full_arready", bus.arready, 0);
        step();
        bus.rready = 1;
        wait_quiet();
        check("lit_rd_count_11", rd_count, 16'd11);

        // reset during a 4-beat read
        step();
        do_ar(5'd9, 16'h0300, 8'd3);
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(negedge clk);
            if (bus.rvalid) n++;
        end
        check("beats_before_rst", n, 2);
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("post_rst_rvalid", bus.rvalid, 0);
        check("post_rst_idle", idle, 1);
        check("post_rst_arready", bus.arready, 1);
        check("post_rst_rd_count", rd_count, 0);

        // the responder keeps working after the abandoned burst
        step();
        do_ar(5'd1, 16'h0500, 8'd0);
        wait_quiet();
        check("leftover_r", exp_r.size(), 0);
        check("leftover_b", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule
